fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the fetch buffer entry count (power of two, >=2).
REQ-003 SHALL have port i_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit, reset; synchronous, active-high.
REQ-005 SHALL have port o_imem_addr, output, `XLEN bits, the byte address driven to instruction memory.
REQ-006 SHALL have port i_imem_inst, input, `INST_WIDTH bits, the instruction returned combinationally for o_imem_addr.
REQ-007 SHALL have port i_redirect, input, 1 bit, a request to flush and restart fetch at i_redirect_pc.
REQ-008 SHALL have port i_redirect_pc, input, `XLEN bits, the redirect target.
REQ-009 SHALL have port i_halt, input, 1 bit, a request to suspend new fetches while high.
REQ-010 SHALL have port o_inst_valid, output, 1 bit, meaning the head buffer entry is presented.
REQ-011 SHALL have port o_inst, output, `INST_WIDTH bits, the head entry instruction.
REQ-012 SHALL have port o_inst_pc, output, `XLEN bits, the head entry address.
REQ-013 SHALL have port i_inst_ready, input, 1 bit, consumer acceptance; a pop occurs when o_inst_valid and i_inst_ready are both high.
REQ-014 SHALL have port o_fault, output, 1 bit, a sticky misaligned-redirect flag.

Function
REQ-015 SHALL hold fetch_pc (`XLEN bits) and drive o_imem_addr = fetch_pc combinationally.
REQ-016 SHALL implement states RUN, HALT and FAULT.
REQ-017 In RUN, a fetch SHALL occur in a cycle when i_redirect=0, i_halt=0, and (count<BUF_DEPTH or a pop occurs that cycle).
REQ-018 A fetch SHALL push {i_imem_inst, fetch_pc} at the clock edge and set fetch_pc <= fetch_pc+4, modulo 2^XLEN (32'hFFFF_FFFC wraps to 0).
REQ-019 A pushed entry SHALL appear on o_inst/o_inst_pc one cycle after its fetch cycle (latency 1).
REQ-020 Entries SHALL be delivered in fetch order; o_inst, o_inst_pc and o_inst_valid SHALL come from registers or buffer storage only.
REQ-021 When the buffer is full and a pop occurs, push and pop SHALL occur in the same cycle; count stays BUF_DEPTH.
REQ-022 When the buffer is full and no pop occurs, there SHALL be no fetch and fetch_pc SHALL hold.
REQ-023 When i_redirect=1 in any state, the buffer SHALL flush (count <= 0) and no push SHALL occur that cycle.
REQ-024 A pop in the same cycle as i_redirect SHALL be a no-op; flush wins.
REQ-025 An aligned redirect (i_redirect_pc[1:0]==0) SHALL set fetch_pc <= i_redirect_pc, clear o_fault, and move to RUN, or to HALT if i_halt=1.
REQ-026 A misaligned redirect SHALL leave fetch_pc unchanged, set o_fault <= 1, and move to FAULT.
REQ-027 In FAULT there SHALL be no fetches; FAULT SHALL be left only by an aligned redirect.
REQ-028 RUN with i_halt=1 (and no redirect) SHALL move to HALT and fetch nothing that cycle.
REQ-029 HALT with i_halt=0 SHALL move to RUN; the first fetch occurs the next cycle.
REQ-030 In HALT, the buffer SHALL keep draining via pops and fetch_pc SHALL hold.
REQ-031 o_inst_valid SHALL equal (count!=0).
REQ-032 o_inst and o_inst_pc SHALL be don't-care when o_inst_valid=0.

Reset
REQ-033 On i_rst=1 at a clock edge, the block SHALL set fetch_pc <= RESET_PC, count <= 0, read/write pointers <= 0, state <= RUN and o_fault <= 0, overriding redirect, halt and pop.
REQ-034 Reset values SHALL be: o_inst_valid=0, o_fault=0, o_imem_addr=RESET_PC.
REQ-035 Reset asserted mid-operation SHALL discard buffered entries; the first fetch after reset occurs in the first cycle with i_rst=0.

Verification
REQ-036 Reset, then i_inst_ready=1 held, memory word n = n -> o_inst_pc sequence 0,4,8,... with o_inst 0,1,2,...; o_inst_valid first high in cycle 2 after reset release, and continuous.
REQ-037 i_inst_ready=0 for 5 cycles -> exactly 2 entries buffered, o_imem_addr frozen at 8; after ready rises, pcs 0,4,8 are delivered with no gap or duplicate.
REQ-038 Redirect to 32'h100 while 2 entries are buffered and ready=1 -> the next valid o_inst_pc is 32'h100; no stale pc is delivered.
REQ-039 Redirect to 32'h102 -> o_fault=1, o_inst_valid=0 one cycle later, o_imem_addr unchanged for 10 cycles; then redirect to 32'h200 -> o_fault=0 and the next o_inst_pc is 32'h200.
REQ-040 Redirect to 32'hFFFF_FFFC with ready=1 -> delivered pcs FFFF_FFFC, 0000_0000, 0000_0004.
REQ-041 i_halt=1 with 2 entries buffered and ready=1 -> both entries drain, then o_inst_valid=0 and the address holds; after halt drops, fetch resumes at the held address.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with a small in-order fetch buffer.
//
// Drives a byte address to a combinational instruction memory, captures the
// returned word together with its address into a FIFO, and presents the head
// entry to a valid/ready consumer. Supports redirect (flush and restart),
// halt (suspend fetching while the buffer drains) and a sticky fault on a
// misaligned redirect target.
//
// Parameters:
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  fetch buffer entries (power of two, >= 2)
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   o_imem_addr    instruction memory byte address (= fetch_pc)
//   i_imem_inst    instruction returned for o_imem_addr
//   i_redirect     flush buffer and restart at i_redirect_pc
//   i_redirect_pc  redirect target
//   i_halt         suspend new fetches while high
//   o_inst_valid   head buffer entry is presented
//   o_inst         head entry instruction
//   o_inst_pc      head entry address
//   i_inst_ready   consumer accepts the head entry
//   o_fault        sticky misaligned-redirect flag

`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module fetch_ctrl #(
    parameter logic [`XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned      BUF_DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic [`XLEN-1:0]       o_imem_addr,
    input  logic [`INST_WIDTH-1:0] i_imem_inst,
    input  logic                   i_redirect,
    input  logic [`XLEN-1:0]       i_redirect_pc,
    input  logic                   i_halt,
    output logic                   o_inst_valid,
    output logic [`INST_WIDTH-1:0] o_inst,
    output logic [`XLEN-1:0]       o_inst_pc,
    input  logic                   i_inst_ready,
    output logic                   o_fault
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [`XLEN-1:0] PC_STEP = `XLEN'(4);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]             state;
    logic [`XLEN-1:0]       fetch_pc;
    logic [CNT_W-1:0]       count;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [`INST_WIDTH-1:0] inst_mem [BUF_DEPTH];
    logic [`XLEN-1:0]       pc_mem   [BUF_DEPTH];

    logic pop;
    logic push;
    logic redirect_aligned;

    assign o_imem_addr  = fetch_pc;
    assign o_inst_valid = (count != '0);
    assign o_inst       = inst_mem[rd_ptr];
    assign o_inst_pc    = pc_mem[rd_ptr];

    assign redirect_aligned = (i_redirect_pc[1:0] == 2'b00);

    // A redirect flushes the buffer, so a coincident handshake must not
    // advance the read side.
    always_comb begin
        pop  = o_inst_valid && i_inst_ready && !i_redirect;
        push = (state == ST_RUN) && !i_redirect && !i_halt &&
               ((count < DEPTH_C) || pop);
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= i_imem_inst;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_RUN;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            o_fault  <= 1'b0;
        end else if (i_redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            if (redirect_aligned) begin
                fetch_pc <= i_redirect_pc;
                o_fault  <= 1'b0;
                state    <= i_halt ? ST_HALT : ST_RUN;
            end else begin
                o_fault <= 1'b1;
                state   <= ST_FAULT;
            end
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_ONE;
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            case (state)
                ST_RUN:   if (i_halt)  state <= ST_HALT;
                ST_HALT:  if (!i_halt) state <= ST_RUN;
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_RUN;
            endcase
        end
    end

endmodule
